mem_port_arbiter: RTL

- Arbitrates the single unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- The memory performs one access per cycle. Reads are combinational; writes commit at posedge clk. The memory applies the data-region offset internally, so this block never adds a base.
- This block grants one requester per cycle, drives the memory control/address/data lines, and registers the returned instruction or load data.
- It enforces bounded data-priority, so a long load/store run cannot starve fetch indefinitely.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port arbiter: data has priority over fetch,
// bounded by MAX_DATA_RUN consecutive data grants while a fetch is waiting.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_instr,
    output logic              if_valid,
    input  logic              flush,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [2:0]        function3,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data_in,
    input  logic [31:0]       data_out
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic             if_valid_q, if_valid_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             d_rvalid_q, d_rvalid_d;

    logic starve;
    logic grant_data;
    logic grant_fetch;

    // Grants are gated by rst_n so nothing reaches memory while in reset.
    assign starve      = if_req && (run_cnt_q == RUN_MAX);
    assign grant_data  = rst_n && d_req && !starve;
    assign grant_fetch = rst_n && if_req && !grant_data;

    // Memory port drive; idle presents the fetch address.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        function3 = 3'b000;
        addr      = if_addr;
        data_in   = 32'h0;
        d_ack     = 1'b0;
        if_ack    = 1'b0;
        if (grant_data) begin
            MemWrite  = d_we;
            MemRead   = !d_we;
            function3 = d_funct3;
            addr      = d_addr;
            data_in   = d_wdata;
            d_ack     = 1'b1;
        end else if (grant_fetch) begin
            if_ack = 1'b1;
        end
    end

    // Next-state for return registers and the data-run counter.
    always_comb begin
        run_cnt_d  = run_cnt_q;
        if_instr_d = if_instr_q;
        if_valid_d = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_rvalid_d = 1'b0;

        if (grant_data) begin
            if (run_cnt_q < RUN_MAX) begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
            end
        end else if (grant_fetch || !d_req) begin
            run_cnt_d = '0;
        end

        if (grant_data && !d_we) begin
            d_rdata_d  = data_out;
            d_rvalid_d = 1'b1;
        end

        // Flush wins over a same-cycle fetch grant; the ack still goes out.
        if (flush) begin
            if_instr_d = NOP_INSTR;
        end else if (grant_fetch) begin
            if_instr_d = data_out;
            if_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q  <= '0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            d_rdata_q  <= 32'h0;
            d_rvalid_q <= 1'b0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            d_rdata_q  <= d_rdata_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    assign if_instr = if_instr_q;
    assign if_valid = if_valid_q;
    assign d_rdata  = d_rdata_q;
    assign d_rvalid = d_rvalid_q;

endmodule
